// File: rtl/switch_pre_pkt_if.sv
// switch_pre_pkt_if: byte-stream ingress plus cell/descriptor FIFO write side of the packer.
// master = the packer (consumes the byte stream, drives the FIFO writes).
// slave  = the surrounding port logic / FIFOs (drives the byte stream, sinks the writes).
interface switch_pre_pkt_if #(
  parameter int CELL_BYTES = 16,
  parameter int PORT_W     = 4,
  parameter int LEN_W      = 11
);
  logic                      sof;
  logic                      dv;
  logic [7:0]                din;
  logic                      i_cell_bp;
  logic [CELL_BYTES*8-1:0]   i_cell_data_fifo_dout;
  logic                      i_cell_data_fifo_wr;
  logic [PORT_W+LEN_W:0]     i_cell_ptr_fifo_dout;
  logic                      i_cell_ptr_fifo_wr;

  modport master (
    input  sof, dv, din, i_cell_bp,
    output i_cell_data_fifo_dout, i_cell_data_fifo_wr,
    output i_cell_ptr_fifo_dout, i_cell_ptr_fifo_wr
  );

  modport slave (
    output sof, dv, din, i_cell_bp,
    input  i_cell_data_fifo_dout, i_cell_data_fifo_wr,
    input  i_cell_ptr_fifo_dout, i_cell_ptr_fifo_wr
  );
endinterface

// File: rtl/switch_pre_pkt.sv
// switch_pre_pkt: packs a sof/dv byte stream into CELL_BYTES-wide cells plus one {trunc, portmap, byte_len} descriptor per frame.
// Latency: a full cell strobes the cycle after its last byte; the descriptor (and any zero-padded tail cell) the cycle after dv falls.
// Backpressure: i_cell_bp is sampled only at sof; a frame starting under bp is dropped whole. Optional SWITCH_PRE_DROP_CNT_EN adds drop_cnt.
module switch_pre_pkt #(
  parameter int CELL_BYTES = 16,
  parameter int PORT_W     = 4,
  parameter int LEN_W      = 11,
  parameter int MAX_CELLS  = 96
) (
  input  logic             clk,
  input  logic             rst,
  switch_pre_pkt_if.master bus
`ifdef SWITCH_PRE_DROP_CNT_EN
  ,
  output logic [15:0]      drop_cnt
`endif
);
  localparam int CELL_W = CELL_BYTES * 8;
  localparam int LANE_W = $clog2(CELL_BYTES);
  localparam int CNT_W  = $clog2(MAX_CELLS + 1);
  localparam int DESC_W = 1 + PORT_W + LEN_W;
  localparam logic [LEN_W-1:0]  MAX_LEN   = LEN_W'(MAX_CELLS * CELL_BYTES);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(CELL_BYTES - 1);
  localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_CELLS);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN, DROP} state_t;
  state_t state, state_nxt;

  logic [CELL_W-1:0] stage, stage_nxt, stage_wr;
  logic [LANE_W-1:0] lane, lane_nxt;
  logic [LEN_W-1:0]  byte_cnt, byte_cnt_nxt;
  logic [CNT_W-1:0]  cell_cnt, cell_cnt_nxt;
  logic [PORT_W-1:0] portmap, portmap_nxt;
  logic [CELL_W-1:0] data_dout, data_dout_nxt;
  logic              data_wr, data_wr_nxt;
  logic [DESC_W-1:0] ptr_dout, ptr_dout_nxt;
  logic              ptr_wr, ptr_wr_nxt;
  logic              drop_evt;

  // Staging view with the incoming byte merged in; lane 0 starts a fresh zeroed cell so tails pad with zeros.
  always_comb begin
    stage_wr = (lane == '0) ? '0 : stage;
    stage_wr[(CELL_BYTES - 1 - int'(lane)) * 8 +: 8] = bus.din;
  end

  // Next-state and next-output logic for the frame FSM.
  always_comb begin
    state_nxt     = state;
    stage_nxt     = stage;
    lane_nxt      = lane;
    byte_cnt_nxt  = byte_cnt;
    cell_cnt_nxt  = cell_cnt;
    portmap_nxt   = portmap;
    data_dout_nxt = data_dout;
    data_wr_nxt   = 1'b0;
    ptr_dout_nxt  = ptr_dout;
    ptr_wr_nxt    = 1'b0;
    drop_evt      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.sof && bus.dv) begin
          if (bus.i_cell_bp) begin
            state_nxt = DROP;
            drop_evt  = 1'b1;
          end else begin
            // lane is always 0 in IDLE, so stage_wr is {din, zeros}
            stage_nxt    = stage_wr;
            portmap_nxt  = bus.din[PORT_W-1:0];
            byte_cnt_nxt = LEN_W'(1);
            lane_nxt     = lane + 1'b1;
            cell_cnt_nxt = '0;
            state_nxt    = FILL;
          end
        end
      end
      FILL: begin
        if (bus.dv) begin
          stage_nxt    = stage_wr;
          byte_cnt_nxt = byte_cnt + 1'b1;
          lane_nxt     = lane + 1'b1;
          if (lane == LAST_LANE) begin
            data_wr_nxt   = 1'b1;
            data_dout_nxt = stage_wr;
            cell_cnt_nxt  = cell_cnt + 1'b1;
            if (cell_cnt + 1'b1 == MAX_CNT) state_nxt = DRAIN;
          end
        end else begin
          // partial tail cell goes out alongside the descriptor
          if (lane != '0) begin
            data_wr_nxt   = 1'b1;
            data_dout_nxt = stage;
          end
          ptr_wr_nxt   = 1'b1;
          ptr_dout_nxt = {1'b0, portmap, byte_cnt};
          lane_nxt     = '0;
          state_nxt    = IDLE;
        end
      end
      DRAIN: begin
        if (!bus.dv) begin
          ptr_wr_nxt   = 1'b1;
          ptr_dout_nxt = {1'b1, portmap, MAX_LEN};
          state_nxt    = IDLE;
        end
      end
      DROP: begin
        if (!bus.dv) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Datapath and registered output strobes/buses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage     <= '0;
      lane      <= '0;
      byte_cnt  <= '0;
      cell_cnt  <= '0;
      portmap   <= '0;
      data_dout <= '0;
      data_wr   <= 1'b0;
      ptr_dout  <= '0;
      ptr_wr    <= 1'b0;
    end else begin
      stage     <= stage_nxt;
      lane      <= lane_nxt;
      byte_cnt  <= byte_cnt_nxt;
      cell_cnt  <= cell_cnt_nxt;
      portmap   <= portmap_nxt;
      data_dout <= data_dout_nxt;
      data_wr   <= data_wr_nxt;
      ptr_dout  <= ptr_dout_nxt;
      ptr_wr    <= ptr_wr_nxt;
    end
  end

  assign bus.i_cell_data_fifo_dout = data_dout;
  assign bus.i_cell_data_fifo_wr   = data_wr;
  assign bus.i_cell_ptr_fifo_dout  = ptr_dout;
  assign bus.i_cell_ptr_fifo_wr    = ptr_wr;

`ifdef SWITCH_PRE_DROP_CNT_EN
  logic [15:0] drop_q;

  // Saturating count of frames rejected at sof.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               drop_q <= '0;
    else if (drop_evt && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
  end

  assign drop_cnt = drop_q;
`else
  logic unused_drop;
  assign unused_drop = drop_evt;
`endif
endmodule

// File: tb/tb_switch_pre_pkt.sv
// tb_switch_pre_pkt: directed table plus random frames on two packers (MAX_CELLS 96 and 4) sharing one byte stream.
// Expected cells/descriptors come from a frame-level model; a negedge monitor pops them on every strobe.
// Optional SWITCH_PRE_DROP_CNT_EN also checks the drop counter.
module tb_switch_pre_pkt;
  localparam int CB = 16;
  localparam int PW = 4;
  localparam int LW = 11;

  logic       clk = 1'b0;
  logic       rst;
  logic       sof, dv, bp;
  logic [7:0] din;

  always #5 clk = ~clk;

  switch_pre_pkt_if #(.CELL_BYTES(CB), .PORT_W(PW), .LEN_W(LW)) b0 ();
  switch_pre_pkt_if #(.CELL_BYTES(CB), .PORT_W(PW), .LEN_W(LW)) b1 ();

  assign b0.sof = sof; assign b0.dv = dv; assign b0.din = din; assign b0.i_cell_bp = bp;
  assign b1.sof = sof; assign b1.dv = dv; assign b1.din = din; assign b1.i_cell_bp = bp;

`ifdef SWITCH_PRE_DROP_CNT_EN
  logic [15:0] dc0, dc1;
`endif

  switch_pre_pkt #(.CELL_BYTES(CB), .PORT_W(PW), .LEN_W(LW), .MAX_CELLS(96)) dut0 (
    .clk(clk), .rst(rst), .bus(b0)
`ifdef SWITCH_PRE_DROP_CNT_EN
    , .drop_cnt(dc0)
`endif
  );

  switch_pre_pkt #(.CELL_BYTES(CB), .PORT_W(PW), .LEN_W(LW), .MAX_CELLS(4)) dut1 (
    .clk(clk), .rst(rst), .bus(b1)
`ifdef SWITCH_PRE_DROP_CNT_EN
    , .drop_cnt(dc1)
`endif
  );

  int n_pass = 0;
  int n_total = 0;
  int drops_model = 0;
  logic [7:0]   frm[$];
  logic [127:0] qc0[$], qc1[$];
  logic [16:0]  qp0[$], qp1[$];   // {tail cell expected in same cycle, descriptor}

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", nm, act, exp);
  endtask

  // Frame-level reference: cut the kept bytes into zero-padded cells, then one descriptor.
  task automatic model(int inst, int maxc);
    int n, lim, kept;
    bit tr, pad;
    logic [127:0] c;
    logic [7:0] h;
    n = frm.size();
    lim = maxc * CB;
    tr = (n >= lim);
    kept = tr ? lim : n;
    for (int s = 0; s < kept; s += CB) begin
      c = '0;
      for (int k = 0; k < CB && s + k < kept; k++) c[127 - 8*k -: 8] = frm[s + k];
      if (inst == 0) qc0.push_back(c); else qc1.push_back(c);
    end
    pad = (kept % CB) != 0;
    h = frm[0];
    if (inst == 0) qp0.push_back({pad, tr, h[3:0], 11'(kept)});
    else           qp1.push_back({pad, tr, h[3:0], 11'(kept)});
  endtask

  task automatic mon(int inst, logic dw, logic [127:0] dd, logic pw, logic [15:0] pd);
    logic [127:0] ec;
    logic [16:0] ep;
    int qs;
    if (dw) begin
      qs = (inst == 0) ? qc0.size() : qc1.size();
      if (qs == 0) begin
        n_total++;
        $display("FAIL dut%0d unexpected data_wr: got %h, want no strobe", inst, dd);
      end else begin
        if (inst == 0) ec = qc0.pop_front(); else ec = qc1.pop_front();
        chk($sformatf("dut%0d cell", inst), dd, ec);
      end
    end
    if (pw) begin
      qs = (inst == 0) ? qp0.size() : qp1.size();
      if (qs == 0) begin
        n_total++;
        $display("FAIL dut%0d unexpected ptr_wr: got %h, want no strobe", inst, pd);
      end else begin
        if (inst == 0) ep = qp0.pop_front(); else ep = qp1.pop_front();
        chk($sformatf("dut%0d descriptor", inst), pd, ep[15:0]);
        if (ep[16]) chk($sformatf("dut%0d tail cell with descriptor", inst), dw, 1);
      end
    end
  endtask

  // Strobe monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      mon(0, b0.i_cell_data_fifo_wr, b0.i_cell_data_fifo_dout, b0.i_cell_ptr_fifo_wr, b0.i_cell_ptr_fifo_dout);
      mon(1, b1.i_cell_data_fifo_wr, b1.i_cell_data_fifo_dout, b1.i_cell_ptr_fifo_wr, b1.i_cell_ptr_fifo_dout);
    end
  end

  task automatic chk_outputs_zero(string tag);
    chk({tag, " dut0 data_dout"}, b0.i_cell_data_fifo_dout, 0);
    chk({tag, " dut0 data_wr"},   b0.i_cell_data_fifo_wr, 0);
    chk({tag, " dut0 ptr_dout"},  b0.i_cell_ptr_fifo_dout, 0);
    chk({tag, " dut0 ptr_wr"},    b0.i_cell_ptr_fifo_wr, 0);
    chk({tag, " dut1 data_dout"}, b1.i_cell_data_fifo_dout, 0);
    chk({tag, " dut1 ptr_wr"},    b1.i_cell_ptr_fifo_wr, 0);
  endtask

  // Drives one frame starting now (caller is just after an edge); ends at the negedge after the descriptor edge.
  task automatic send_frame(int len, logic [7:0] hdr, bit bpv, bit noisy,
                            output logic [15:0] o0, output logic [15:0] o1, output logic [127:0] c0);
    frm.delete();
    frm.push_back(hdr);
    for (int j = 1; j < len; j++) frm.push_back(8'($urandom));
    if (bpv) drops_model++;
    else begin
      model(0, 96);
      model(1, 4);
    end
    sof = 1'b1; dv = 1'b1; din = hdr; bp = bpv;
    for (int j = 1; j < len; j++) begin
      @(posedge clk); #1;
      sof = noisy && ($urandom_range(0, 7) == 0);
      din = frm[j];
      bp  = noisy ? 1'($urandom) : 1'b0;
    end
    @(posedge clk); #1;
    sof = 1'b0; dv = 1'b0; din = 8'h00; bp = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("dut0 descriptor timing", b0.i_cell_ptr_fifo_wr, bpv ? 1'b0 : 1'b1);
    chk("dut1 descriptor timing", b1.i_cell_ptr_fifo_wr, bpv ? 1'b0 : 1'b1);
    o0 = b0.i_cell_ptr_fifo_dout;
    o1 = b1.i_cell_ptr_fifo_dout;
    c0 = b0.i_cell_data_fifo_dout;
  endtask

  typedef struct {
    int          len;
    logic [7:0]  hdr;
    bit          bp;
    logic [15:0] p0;   // descriptor, MAX_CELLS = 96
    logic [15:0] p1;   // descriptor, MAX_CELLS = 4
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [15:0]  o0, o1;
    logic [127:0] c0;
    logic [127:0] one_byte_cell;

    tbl[0] = '{64,  8'h05, 1'b0, 16'h2840, 16'hA840};
    tbl[1] = '{20,  8'h05, 1'b0, 16'h2814, 16'h2814};
    tbl[2] = '{60,  8'h05, 1'b1, 16'h0000, 16'h0000};
    tbl[3] = '{16,  8'h03, 1'b0, 16'h1810, 16'h1810};
    tbl[4] = '{100, 8'h05, 1'b0, 16'h2864, 16'hA840};
    tbl[5] = '{1,   8'h0A, 1'b0, 16'h5001, 16'h5001};
    tbl[6] = '{17,  8'h0A, 1'b0, 16'h5011, 16'h5011};
    one_byte_cell = {8'h0A, 120'h0};

    rst = 1'b1; sof = 1'b0; dv = 1'b0; din = 8'h00; bp = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_outputs_zero("reset");
`ifdef SWITCH_PRE_DROP_CNT_EN
    chk("reset drop_cnt", dc0, 0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of a frame: nothing from it may ever appear.
    sof = 1'b1; dv = 1'b1; din = 8'h03;
    for (int j = 1; j < 7; j++) begin
      @(posedge clk); #1;
      sof = 1'b0; din = 8'(j);
    end
    @(posedge clk); #1;
    rst = 1'b1; din = 8'h55;
    @(negedge clk);
    chk_outputs_zero("mid-frame reset");
    @(posedge clk); #1;
    rst = 1'b0;
    for (int j = 0; j < 20; j++) begin
      @(posedge clk); #1;
      din = 8'($urandom);
    end
    dv = 1'b0;
    @(posedge clk); #1;
    send_frame(16, 8'h03, 1'b0, 1'b0, o0, o1, c0);
    chk("post-reset frame dut0", o0, 16'h1810);
    chk("post-reset frame dut1", o1, 16'h1810);

    // Directed table; frames follow each other with the minimum gap.
    for (int i = 0; i < 7; i++) begin
      send_frame(tbl[i].len, tbl[i].hdr, tbl[i].bp, 1'b0, o0, o1, c0);
      if (!tbl[i].bp) begin
        chk($sformatf("table %0d dut0 descriptor", i), o0, tbl[i].p0);
        chk($sformatf("table %0d dut1 descriptor", i), o1, tbl[i].p1);
      end
      if (tbl[i].len == 1) chk("one-byte padded cell", c0, one_byte_cell);
`ifdef SWITCH_PRE_DROP_CNT_EN
      if (tbl[i].bp) chk("drop_cnt after drop", dc0, 1);
`endif
    end

    // Random frames: mid-frame sof and bp noise, random gaps, bp at sof one time in five.
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      send_frame($urandom_range(1, 90), 8'($urandom), $urandom_range(0, 4) == 0, 1'b1, o0, o1, c0);
    end

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("dut0 cells outstanding", qc0.size(), 0);
    chk("dut0 descriptors outstanding", qp0.size(), 0);
    chk("dut1 cells outstanding", qc1.size(), 0);
    chk("dut1 descriptors outstanding", qp1.size(), 0);
`ifdef SWITCH_PRE_DROP_CNT_EN
    chk("final drop_cnt dut0", dc0, drops_model);
    chk("final drop_cnt dut1", dc1, drops_model);
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
